// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word and RAM status encodings, plus the
// memory arbiter's state and latched-request types.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, IACC, DACC, FAULT} arb_state_t;

  // Request captured at grant; data is unused for fetches.
  typedef struct packed {
    word_t addr;
    word_t data;
    logic  wr;
  } mem_req_t;

endpackage

// File: rtl/access_timer.sv
// Access watchdog: counts cycles while enabled and flags the cycle in which
// the count would reach TIMEOUT.
module access_timer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 7
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)        cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end

  // tc fires in the TIMEOUT-th enabled cycle since the last clear.
  assign tc = en && (({1'b0, cnt} + (CW+1)'(1)) == (CW+1)'(TIMEOUT));

endmodule

// File: rtl/mem_request_arbiter.sv
// Arbitrates pipeline fetch/data requests onto a single-ported RAM and
// returns one hit pulse per completed access; faults stick until reset.
module mem_request_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 7
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        fault
);

  arb_state_t state, state_nxt;
  mem_req_t   req_q, req_d;
  ramstate_t  rs;
  logic       grant, own_req, in_acc, tc;

  assign rs     = ramstate_t'(ramstate);
  assign in_acc = (state == IACC) || (state == DACC);
  assign fault  = (state == FAULT);

  access_timer #(.TIMEOUT(TIMEOUT), .CW(CW)) u_timer (
    .gclk   (CLK),
    .grst_n (nRST),
    .clr    (grant),
    .en     (in_acc),
    .tc     (tc)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      req_q <= req_d;
    end
  end

  always_comb begin
    state_nxt = state;
    req_d     = req_q;
    grant     = 1'b0;
    own_req   = 1'b0;
    ihit      = 1'b0;
    dhit      = 1'b0;
    iload     = '0;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    case (state)
      IDLE: begin
        if (dREN || dWEN) begin
          grant     = 1'b1;
          state_nxt = DACC;
          req_d     = '{addr: daddr, data: dstore, wr: dWEN};
        end else if (iREN) begin
          grant     = 1'b1;
          state_nxt = IACC;
          req_d     = '{addr: iaddr, data: '0, wr: 1'b0};
        end
      end
      IACC, DACC: begin
        // Only the request that won the grant keeps the access alive.
        own_req = (state == IACC) ? iREN : (req_q.wr ? dWEN : dREN);
        if (own_req) begin
          ramaddr  = req_q.addr;
          ramstore = req_q.data;
          ramREN   = (state == IACC) || !req_q.wr;
          ramWEN   = (state == DACC) && req_q.wr;
        end
        if (!own_req) begin
          state_nxt = IDLE;
        end else if (rs == ACCESS) begin
          state_nxt = IDLE;
          if (state == IACC) begin
            ihit  = 1'b1;
            iload = ramload;
          end else begin
            dhit  = 1'b1;
            dload = req_q.wr ? '0 : ramload;
          end
        end else if ((rs == ERROR) || tc) begin
          state_nxt = FAULT;
        end
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Scoreboarded bench for mem_request_arbiter: expected hits are queued as
// stimulus is driven and retired by a negedge monitor.
module tb_mem_request_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, fault;

  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

  typedef struct packed {
    logic        is_d;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_request_arbiter #(.TIMEOUT(4), .CW(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .fault(fault)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ren"}, ramREN, 0);
    chk({tag, "_wen"}, ramWEN, 0);
  endtask

  // Every hit must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (nRST && (ihit || dhit)) begin
      if (ihit && dhit) chk("both_hits", {ihit, dhit}, 2'b01);
      else if (sb.size() == 0) chk("unexpected_hit", {30'b0, ihit, dhit}, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("hit_is_d", dhit, e.is_d);
        if (e.chk_data) chk("hit_data", dhit ? dload : iload, e.data);
      end
    end
  end

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = RS_FREE;
    #2;
    chk("rst_ren", ramREN, 0);
    chk("rst_addr", ramaddr, 0);
    chk("rst_fault", fault, 0);
    chk("rst_hits", {ihit, dhit}, 0);
    step(); step();
    nRST = 1'b1;
    @(negedge CLK);
    chk_quiet("post_rst");

    // Fetch with two BUSY cycles; address change mid-access is ignored.
    step(); iREN = 1; iaddr = 32'h40; ramstate = RS_BUSY; ramload = 32'h2008_0001;
    @(negedge CLK); chk("t1_c0_ren", ramREN, 0);
    step(); @(negedge CLK); chk("t1_c1_ren", ramREN, 1); chk("t1_c1_addr", ramaddr, 32'h40);
    step(); iaddr = 32'h44;
    @(negedge CLK); chk("t1_c2_ren", ramREN, 1); chk("t1_c2_addr", ramaddr, 32'h40);
    step(); ramstate = RS_ACCESS; sb.push_back('{1'b0, 1'b1, 32'h2008_0001});
    @(negedge CLK); chk("t1_c3_ren", ramREN, 1);
    step(); iREN = 0; ramstate = RS_FREE;
    @(negedge CLK); chk_quiet("t1_c4");

    // Simultaneous fetch and store: data wins, fetch follows after one idle.
    step(); iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100;
    dstore = 32'hDEAD_BEEF; ramstate = RS_ACCESS; ramload = 32'hCAFE_0000;
    @(negedge CLK); chk_quiet("t2_c0");
    step(); sb.push_back('{1'b1, 1'b0, 32'h0});
    @(negedge CLK);
    chk("t2_c1_wen", ramWEN, 1); chk("t2_c1_ren", ramREN, 0);
    chk("t2_c1_addr", ramaddr, 32'h100); chk("t2_c1_store", ramstore, 32'hDEAD_BEEF);
    step(); dWEN = 0;
    @(negedge CLK); chk_quiet("t2_c2");
    step(); ramload = 32'h1234_5678; sb.push_back('{1'b0, 1'b1, 32'h1234_5678});
    @(negedge CLK); chk("t2_c3_ren", ramREN, 1); chk("t2_c3_addr", ramaddr, 32'h80);
    step(); iREN = 0; ramstate = RS_FREE;

    // Load withdrawn while BUSY: no hit, and the next cycle is a grant cycle.
    step(); dREN = 1; daddr = 32'h200; ramstate = RS_BUSY;
    step(); @(negedge CLK); chk("t3_c1_ren", ramREN, 1); chk("t3_c1_addr", ramaddr, 32'h200);
    step(); dREN = 0;
    @(negedge CLK); chk_quiet("t3_abort");
    step(); dREN = 1; ramstate = RS_ACCESS; ramload = 32'h55AA_55AA;
    @(negedge CLK); chk_quiet("t3_idle_after_abort");
    step(); sb.push_back('{1'b1, 1'b1, 32'h55AA_55AA});
    @(negedge CLK); chk("t3_c4_ren", ramREN, 1);
    step(); dREN = 0; ramstate = RS_FREE;

    // Short reset pulse in the middle of a load.
    step(); dREN = 1; daddr = 32'h300; ramstate = RS_BUSY;
    step(); @(negedge CLK); chk("t4_c1_ren", ramREN, 1);
    step(); #1 nRST = 0;
    #1;
    chk("t4_rst_ren", ramREN, 0); chk("t4_rst_addr", ramaddr, 0);
    chk("t4_rst_hits", {ihit, dhit}, 0); chk("t4_rst_fault", fault, 0);
    #1 nRST = 1; dREN = 0;
    @(negedge CLK); chk_quiet("t4_post");
    step(); iREN = 1; iaddr = 32'h400; ramstate = RS_ACCESS; ramload = 32'h0BAD_F00D;
    step(); sb.push_back('{1'b0, 1'b1, 32'h0BAD_F00D});
    @(negedge CLK); chk("t4_ren", ramREN, 1); chk("t4_addr", ramaddr, 32'h400); chk("t4_fault", fault, 0);
    step(); iREN = 0; ramstate = RS_FREE;

    // RAM ERROR during a load faults the block.
    step(); dREN = 1; daddr = 32'h500; ramstate = RS_ERROR;
    step(); @(negedge CLK); chk("t5_c1_fault", fault, 0);
    step(); iREN = 1;
    @(negedge CLK); chk("t5_fault", fault, 1); chk_quiet("t5_faulted");
    step(); @(negedge CLK); chk_quiet("t5_hold");
    step(); iREN = 0; dREN = 0; ramstate = RS_FREE; nRST = 0;
    #2 nRST = 1;
    @(negedge CLK); chk("t5_fault_cleared", fault, 0);

    // Timeout: fetch held BUSY for TIMEOUT=4 access cycles.
    step(); iREN = 1; iaddr = 32'h600; ramstate = RS_BUSY;
    for (int k = 1; k <= 4; k++) begin
      step(); @(negedge CLK);
      chk($sformatf("t6_c%0d_ren", k), ramREN, 1);
      chk($sformatf("t6_c%0d_fault", k), fault, 0);
    end
    step(); @(negedge CLK); chk("t6_fault", fault, 1); chk_quiet("t6_c5");
    step(); dWEN = 1; daddr = 32'h700; ramstate = RS_ACCESS;
    for (int k = 0; k < 3; k++) begin
      step(); @(negedge CLK);
      chk_quiet($sformatf("t6_stuck%0d", k));
      chk($sformatf("t6_stuck%0d_fault", k), fault, 1);
    end
    step(); iREN = 0; dWEN = 0; ramstate = RS_FREE;
    @(negedge CLK);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
- Memory-side responder for the pipeline's fetch and data request enables (iREN, dREN, dWEN); the hazard logic stalls on the ihit/dhit this block produces.
- Arbitrates instruction and data requests onto the single-ported RAM interface. Latches the address and store data at grant. Tracks RAM readiness. Returns exactly one hit pulse per completed access, with load data.

Parameters:
- TIMEOUT, 64, cycles in an access state without ramstate==ACCESS before the block declares a fault.
- CW, 7, width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address (word_t).
- iload  out  32  instruction read data; valid only in the ihit cycle.
- ihit  out  1  one-cycle pulse: instruction access complete.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; dREN and dWEN are never both 1.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dload  out  32  data read data; valid only in the dhit cycle.
- dhit  out  1  one-cycle pulse: data access complete.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- fault  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous, active-low. Reset forces state IDLE, counter 0, latched address/data 0 and fault 0. Every output is 0 during and after reset until the first grant.
- States: IDLE, IACC, DACC, FAULT (arb_state_t).
- Arbitration in IDLE:
  - (dREN|dWEN) takes priority over iREN. Next state is DACC, latching daddr, dstore and the read/write kind.
  - Otherwise, iREN goes to IACC, latching iaddr.
  - With no request, stay in IDLE.
  - Grant decision costs 1 cycle. The earliest possible hit is the cycle after the grant.
- In IACC or DACC:
  - ramaddr and ramstore are driven from the latches.
  - IACC drives ramREN=1. DACC drives ramREN or ramWEN according to the latched kind.
- Completion:
  - ramstate==ACCESS in IACC gives ihit=1 and iload=ramload, combinationally in that cycle.
  - ramstate==ACCESS in DACC gives dhit=1, with dload=ramload on reads.
  - The state then returns to IDLE. Back-to-back accesses cost 1 idle cycle each. ihit and dhit are never both 1.
- Withdrawal: if the owning request drops before ACCESS, the access is aborted. RAM enables drop in the same cycle, no hit is issued, and the state goes to IDLE. A write aborted this way may already be partly committed; this is documented, not prevented.
- Request change mid-access: a change of address on a still-asserted request has no effect until re-grant.
- Timeout and fault:
  - The counter clears on every grant and increments each cycle spent in IACC/DACC.
  - If it reaches TIMEOUT, or ramstate==ERROR, the state moves to FAULT and fault is set to 1.
  - FAULT drives all RAM enables 0 and no hits. It is left only by reset.
- Starvation: a data request arriving during IACC waits for that access to complete, then wins. Instruction fetch cannot starve data; data can stall fetch indefinitely, which is acceptable.
- Reset mid-access: RAM enables drop asynchronously and no hit is emitted.

Decomposition:
- cpu_types_pkg: word_t, ramstate_t (existing).
- New in cpu_types_pkg: arb_state_t enum {IDLE, IACC, DACC, FAULT}.
- Timeout comparison is expressed inside the package-typed logic; no extra constants.
- Natural single sub-module: access_timer (counter with clear, enable and terminal-count flag), instantiated once.
- FSM, latches and output muxing stay in mem_request_arbiter.

Test Plan:
- iREN=1, iaddr=0x0000_0040, ramstate BUSY for 2 cycles then ACCESS, ramload=0x2008_0001 -> ramREN=1 with ramaddr=0x40 from cycle 1; ihit pulses exactly once in cycle 3 with iload=0x2008_0001; ihit=0 otherwise.
- iREN=1 and dWEN=1 in the same cycle, daddr=0x100, dstore=0xDEAD_BEEF, RAM ACCESS immediately -> data granted first: ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF, dhit in cycle 1; IDLE cycle 2; ramREN with ramaddr=iaddr from cycle 3.
- dREN=1 then dropped after 1 cycle with ramstate BUSY -> enables drop that cycle, no dhit, IDLE next cycle.
- TIMEOUT=4, iREN=1, ramstate held BUSY -> fault=1 after 4 access cycles; no ihit; enables 0 thereafter, even with new requests.
- nRST pulled low for a fraction of a cycle mid-DACC -> all outputs 0 immediately; after release, the first request is granted normally and fault=0.
